dequant_expand: RTL and testbench

- Streaming widening converter. Takes signed 8-bit fixed-point samples with binary point RsBp_i and produces OPWIDTH-bit signed samples with binary point OpBp_i.
- It is the inverse direction of the narrowing alignment stage used in front of the 8-bit datapath.
- It sits between the 8-bit processing core and the wide accumulator/DMA side.
- Two-stage pipeline with valid/ready flow control on both sides, plus a per-sample overflow flag and a sticky overflow flag.

---
 rtl/fxp_pkg.sv | 24 ++
 rtl/fxp_shift_sat.sv | 42 ++++
 rtl/dequant_expand.sv | 104 ++++++++++
 tb/tb_dequant_expand.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Shared fixed-point constants, saturation helpers and the stage-1 payload type
// used by the widening (dequant) datapaths.
package fxp_pkg;

    localparam int DATA8_W = 8;
    localparam int RSBP_W  = 4;
    localparam int OPBP_W  = 5;

    typedef struct packed {
        logic signed [DATA8_W-1:0] d;
        logic                      l;
        logic [OPBP_W-1:0]         k;
    } stg1_t;

    function automatic logic [31:0] sat_max(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    // The low w bits of this pattern are the two's-complement encoding of -2^(w-1).
    function automatic logic [31:0] sat_min(input int w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fxp_shift_sat.sv
// Combinational widening shifter: left/arithmetic-right shift of an 8-bit sample,
// overflow detection at OPWIDTH, clamp when DEQUANT_EXPAND_SATURATE_EN is defined, wrap otherwise.
module fxp_shift_sat
    import fxp_pkg::*;
#(
    parameter int OPWIDTH = 24
) (
    input  logic signed [DATA8_W-1:0] i_d,
    input  logic                      i_l,
    input  logic [OPBP_W-1:0]         i_k,
    output logic [OPWIDTH-1:0]        o_q,
    output logic                      o_ovf
);

    localparam int FW = OPWIDTH + 31;

    logic signed [FW-1:0]      w_ext;
    logic signed [FW-1:0]      w_shl;
    logic signed [FW-1:0]      w_shr;
    logic signed [FW-1:0]      w_res;
    logic [FW-OPWIDTH:0]       w_top;

    assign w_ext = {{(FW-DATA8_W){i_d[DATA8_W-1]}}, i_d};
    assign w_shl = w_ext <<< i_k;
    // Arithmetic right shift already yields 0 / -1 once K reaches the sample width.
    assign w_shr = w_ext >>> i_k;
    assign w_res = i_l ? w_shl : w_shr;
    assign w_top = w_res[FW-1:OPWIDTH-1];

    assign o_ovf = i_l & ~((&w_top) | ~(|w_top));

`ifdef DEQUANT_EXPAND_SATURATE_EN
    localparam logic [OPWIDTH-1:0] SAT_HI = OPWIDTH'(sat_max(OPWIDTH));
    localparam logic [OPWIDTH-1:0] SAT_LO = OPWIDTH'(sat_min(OPWIDTH));

    assign o_q = !o_ovf ? w_res[OPWIDTH-1:0]
               : (i_d[DATA8_W-1] ? SAT_LO : SAT_HI);
`else
    assign o_q = w_res[OPWIDTH-1:0];
`endif

endmodule

// File: rtl/dequant_expand.sv
// Two-stage streaming widening converter (8-bit fixed point -> OPWIDTH-bit) with
// valid/ready on both sides and sticky overflow; DEQUANT_EXPAND_SATURATE_EN selects clamp over wrap.
module dequant_expand
    import fxp_pkg::*;
#(
    parameter int OPWIDTH = 24
) (
    input  logic               Clk_i,
    input  logic               Rst_i,
    input  logic               Vld_i,
    output logic               Rdy_o,
    input  logic [7:0]         D_i,
    input  logic [3:0]         RsBp_i,
    input  logic [4:0]         OpBp_i,
    output logic               Vld_o,
    input  logic               Rdy_i,
    output logic [OPWIDTH-1:0] Q_o,
    output logic               Ovf_o,
    output logic               OvfSticky_o,
    input  logic               ClrOvf_i
);

    logic               r_vld_p1;
    stg1_t              r_pay_p1;
    logic               r_vld_p2;
    logic [OPWIDTH-1:0] r_q_p2;
    logic               r_ovf_p2;
    logic               r_ovf_sticky;

    logic               w_ld_p1;
    logic               w_ld_p2;
    logic               w_dir_l;
    logic [OPBP_W-1:0]  w_rsbp_ext;
    stg1_t              w_pay;
    logic [OPWIDTH-1:0] w_q;
    logic               w_ovf;

    assign w_ld_p2 = ~r_vld_p2 | Rdy_i;
    assign w_ld_p1 = ~r_vld_p1 | w_ld_p2;
    assign Rdy_o   = w_ld_p1;

    assign w_rsbp_ext = {1'b0, RsBp_i};
    assign w_dir_l    = (OpBp_i >= w_rsbp_ext);
    assign w_pay.d    = $signed(D_i);
    assign w_pay.l    = w_dir_l;
    assign w_pay.k    = w_dir_l ? (OpBp_i - w_rsbp_ext) : (w_rsbp_ext - OpBp_i);

    // ---- stage 1: capture sample, direction and shift distance ----
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            r_vld_p1 <= 1'b0;
        end else if (w_ld_p1) begin
            r_vld_p1 <= Vld_i;
        end
    end

    always_ff @(posedge Clk_i) begin
        if (w_ld_p1 && Vld_i) begin
            r_pay_p1 <= w_pay;
        end
    end

    fxp_shift_sat #(
        .OPWIDTH (OPWIDTH)
    ) u_shift_sat (
        .i_d   (r_pay_p1.d),
        .i_l   (r_pay_p1.l),
        .i_k   (r_pay_p1.k),
        .o_q   (w_q),
        .o_ovf (w_ovf)
    );

    // ---- stage 2: output register, held while downstream stalls ----
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            r_vld_p2 <= 1'b0;
            r_q_p2   <= '0;
            r_ovf_p2 <= 1'b0;
        end else if (w_ld_p2) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_q_p2   <= w_q;
                r_ovf_p2 <= w_ovf;
            end
        end
    end

    // Set takes priority over clear when both land in the same cycle.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            r_ovf_sticky <= 1'b0;
        end else if (r_vld_p2 && Rdy_i && r_ovf_p2) begin
            r_ovf_sticky <= 1'b1;
        end else if (ClrOvf_i) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign Vld_o       = r_vld_p2;
    assign Q_o         = r_q_p2;
    assign Ovf_o       = r_ovf_p2;
    assign OvfSticky_o = r_ovf_sticky;

endmodule

// File: tb/tb_dequant_expand.sv
// Bench for dequant_expand (OPWIDTH=24), directed vectors plus randomized traffic
// against an arithmetic reference model; honours DEQUANT_EXPAND_SATURATE_EN.
module tb_dequant_expand;

    localparam int OPW = 24;

    logic           clk = 1'b0;
    logic           rst;
    logic           vld_i;
    logic           rdy_o;
    logic [7:0]     d_i;
    logic [3:0]     rs_i;
    logic [4:0]     op_i;
    logic           vld_o;
    logic           rdy_i;
    logic [OPW-1:0] q_o;
    logic           ovf_o;
    logic           sticky_o;
    logic           clr;

    int n_pass = 0;
    int n_chk  = 0;

    logic [OPW:0] obs_q[$];
    logic [OPW:0] exp_q[$];

    always #5 clk = ~clk;

    dequant_expand #(.OPWIDTH(OPW)) dut (
        .Clk_i       (clk),
        .Rst_i       (rst),
        .Vld_i       (vld_i),
        .Rdy_o       (rdy_o),
        .D_i         (d_i),
        .RsBp_i      (rs_i),
        .OpBp_i      (op_i),
        .Vld_o       (vld_o),
        .Rdy_i       (rdy_i),
        .Q_o         (q_o),
        .Ovf_o       (ovf_o),
        .OvfSticky_o (sticky_o),
        .ClrOvf_i    (clr)
    );

    // Reference: value * 2^(OpBp-RsBp) with floor division for negative exponents.
    function automatic logic [OPW:0] model(input logic [7:0] d, input int rs, input int op);
        longint dv, full, p, maxv, minv;
        logic ovf;
        logic [OPW-1:0] q;
        dv   = longint'($signed(d));
        maxv = (longint'(1) << (OPW - 1)) - 1;
        minv = -(longint'(1) << (OPW - 1));
        if (op >= rs) begin
            full = dv * (longint'(1) << (op - rs));
        end else begin
            p    = longint'(1) << (rs - op);
            full = (dv >= 0) ? (dv / p) : -((-dv + p - 1) / p);
        end
        ovf = (full > maxv) || (full < minv);
`ifdef DEQUANT_EXPAND_SATURATE_EN
        if (ovf) full = (dv < 0) ? minv : maxv;
`endif
        q = full[OPW-1:0];
        return {ovf, q};
    endfunction

    always @(negedge clk) begin
        if (!rst && vld_o && rdy_i) obs_q.push_back({ovf_o, q_o});
        if (!rst && vld_i && rdy_o) exp_q.push_back(model(d_i, int'(rs_i), int'(op_i)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; vld_i = 1'b0; rdy_i = 1'b0; clr = 1'b0;
        d_i = '0; rs_i = '0; op_i = '0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (vld_o !== 1'b0) $display("FAIL reset_vld got=%b want=0", vld_o); else n_pass++;
        n_chk++; if (q_o !== '0) $display("FAIL reset_q got=%h want=0", q_o); else n_pass++;
        n_chk++; if (ovf_o !== 1'b0) $display("FAIL reset_ovf got=%b want=0", ovf_o); else n_pass++;
        n_chk++; if (sticky_o !== 1'b0) $display("FAIL reset_sticky got=%b want=0", sticky_o); else n_pass++;
        n_chk++; if (rdy_o !== 1'b1) $display("FAIL reset_rdy got=%b want=1", rdy_o); else n_pass++;
        tick();
    endtask

    task automatic test_directed();
        logic [7:0]     td [12] = '{8'h40, 8'h80, 8'h7F, 8'h81, 8'h7F, 8'h85,
                                    8'h7F, 8'h00, 8'h01, 8'h80, 8'h80, 8'h7F};
        logic [3:0]     trs[12] = '{4'd6, 4'd7, 4'd4, 4'd4, 4'd0, 4'd15,
                                    4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3};
        logic [4:0]     top[12] = '{5'd16, 5'd20, 5'd1, 5'd1, 5'd20, 5'd0,
                                    5'd0, 5'd31, 5'd23, 5'd16, 5'd17, 5'd3};
`ifdef DEQUANT_EXPAND_SATURATE_EN
        logic [OPW-1:0] tq [12] = '{24'h010000, 24'hF00000, 24'h00000F, 24'hFFFFF0, 24'h7FFFFF, 24'hFFFFFF,
                                    24'h000000, 24'h000000, 24'h7FFFFF, 24'h800000, 24'h800000, 24'h00007F};
`else
        logic [OPW-1:0] tq [12] = '{24'h010000, 24'hF00000, 24'h00000F, 24'hFFFFF0, 24'hF00000, 24'hFFFFFF,
                                    24'h000000, 24'h000000, 24'h800000, 24'h800000, 24'h000000, 24'h00007F};
`endif
        logic           tov[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        rdy_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            vld_i = 1'b1; d_i = td[i]; rs_i = trs[i]; op_i = top[i];
            tick();
            vld_i = 1'b0;
            tick();
            @(negedge clk);
            n_chk++; if (vld_o !== 1'b1) $display("FAIL dir%0d_vld got=%b want=1", i, vld_o); else n_pass++;
            n_chk++; if (q_o !== tq[i]) $display("FAIL dir%0d_q got=%h want=%h", i, q_o, tq[i]); else n_pass++;
            n_chk++; if (ovf_o !== tov[i]) $display("FAIL dir%0d_ovf got=%b want=%b", i, ovf_o, tov[i]); else n_pass++;
            tick();
        end
    endtask

    task automatic test_sticky();
        rdy_i = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        n_chk++; if (sticky_o !== 1'b0) $display("FAIL sticky_clr0 got=%b want=0", sticky_o); else n_pass++;
        tick();
        vld_i = 1'b1; d_i = 8'h40; rs_i = 4'd6; op_i = 5'd16;
        tick();
        vld_i = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_chk++; if (sticky_o !== 1'b0) $display("FAIL sticky_noovf got=%b want=0", sticky_o); else n_pass++;
        tick();
        vld_i = 1'b1; d_i = 8'h7F; rs_i = 4'd0; op_i = 5'd20;
        tick();
        vld_i = 1'b0;
        tick();
        @(negedge clk);
        n_chk++; if (sticky_o !== 1'b0) $display("FAIL sticky_pre got=%b want=0", sticky_o); else n_pass++;
        tick();
        @(negedge clk);
        n_chk++; if (sticky_o !== 1'b1) $display("FAIL sticky_set got=%b want=1", sticky_o); else n_pass++;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        n_chk++; if (sticky_o !== 1'b0) $display("FAIL sticky_clr got=%b want=0", sticky_o); else n_pass++;
        tick();
        vld_i = 1'b1; d_i = 8'h81; rs_i = 4'd0; op_i = 5'd24;
        tick();
        vld_i = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        n_chk++; if (sticky_o !== 1'b1) $display("FAIL sticky_setwins got=%b want=1", sticky_o); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int             idx = 0;
        bit             saw_low = 1'b0;
        bit             prev_stall = 1'b0;
        logic [OPW-1:0] prev_q = '0;
        logic [7:0]     sd [5];
        logic [3:0]     srs[5];
        logic [4:0]     sop[5];
        for (int i = 0; i < 5; i++) begin
            sd[i] = 8'($urandom); srs[i] = 4'($urandom_range(0, 15)); sop[i] = 5'($urandom_range(0, 31));
        end
        obs_q.delete(); exp_q.delete();
        for (int c = 0; c < 20; c++) begin
            rdy_i = !(c >= 3 && c < 6);
            vld_i = (idx < 5);
            if (idx < 5) begin d_i = sd[idx]; rs_i = srs[idx]; op_i = sop[idx]; end
            @(negedge clk);
            if (prev_stall) begin
                n_chk++; if (vld_o !== 1'b1) $display("FAIL bp_hold_vld c=%0d got=%b want=1", c, vld_o); else n_pass++;
                n_chk++; if (q_o !== prev_q) $display("FAIL bp_hold_q c=%0d got=%h want=%h", c, q_o, prev_q); else n_pass++;
            end
            prev_stall = vld_o && !rdy_i;
            prev_q = q_o;
            if (!rdy_o) saw_low = 1'b1;
            if (vld_i && rdy_o) idx++;
            tick();
        end
        vld_i = 1'b0;
        n_chk++; if (saw_low !== 1'b1) $display("FAIL bp_rdy_drop got=%b want=1", saw_low); else n_pass++;
        n_chk++; if (obs_q.size() != 5) $display("FAIL bp_count got=%0d want=5", obs_q.size()); else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_chk++; if (obs_q[i] !== exp_q[i]) $display("FAIL bp_data%0d got=%h want=%h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_random();
        bit             prev_stall = 1'b0;
        logic [OPW-1:0] prev_q = '0;
        obs_q.delete(); exp_q.delete();
        for (int c = 0; c < 600; c++) begin
            vld_i = ($urandom_range(0, 9) < 7);
            rdy_i = ($urandom_range(0, 9) < 7);
            d_i = 8'($urandom); rs_i = 4'($urandom_range(0, 15)); op_i = 5'($urandom_range(0, 31));
            @(negedge clk);
            if (prev_stall) begin
                n_chk++; if (q_o !== prev_q) $display("FAIL rnd_hold c=%0d got=%h want=%h", c, q_o, prev_q); else n_pass++;
            end
            prev_stall = vld_o && !rdy_i;
            prev_q = q_o;
            tick();
        end
        vld_i = 1'b0; rdy_i = 1'b1;
        repeat (4) tick();
        n_chk++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL rnd_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_chk++; if (obs_q[i] !== exp_q[i]) $display("FAIL rnd_data%0d got=%h want=%h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        rdy_i = 1'b1;
        vld_i = 1'b1; d_i = 8'h7F; rs_i = 4'd0; op_i = 5'd20;
        tick();
        vld_i = 1'b0;
        repeat (3) tick();
        obs_q.delete(); exp_q.delete();
        rdy_i = 1'b0;
        vld_i = 1'b1; d_i = 8'h7F; rs_i = 4'd0; op_i = 5'd20;
        tick();
        d_i = 8'h22; rs_i = 4'd2; op_i = 5'd9;
        tick();
        vld_i = 1'b0;
        @(negedge clk);
        n_chk++; if (vld_o !== 1'b1) $display("FAIL rm_full_vld got=%b want=1", vld_o); else n_pass++;
        n_chk++; if (rdy_o !== 1'b0) $display("FAIL rm_full_rdy got=%b want=0", rdy_o); else n_pass++;
        n_chk++; if (sticky_o !== 1'b1) $display("FAIL rm_pre_sticky got=%b want=1", sticky_o); else n_pass++;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (vld_o !== 1'b0) $display("FAIL rm_vld got=%b want=0", vld_o); else n_pass++;
        n_chk++; if (q_o !== '0) $display("FAIL rm_q got=%h want=0", q_o); else n_pass++;
        n_chk++; if (ovf_o !== 1'b0) $display("FAIL rm_ovf got=%b want=0", ovf_o); else n_pass++;
        n_chk++; if (sticky_o !== 1'b0) $display("FAIL rm_sticky got=%b want=0", sticky_o); else n_pass++;
        n_chk++; if (rdy_o !== 1'b1) $display("FAIL rm_rdy got=%b want=1", rdy_o); else n_pass++;
        tick();
        rdy_i = 1'b1;
        repeat (5) tick();
        n_chk++; if (obs_q.size() != 0) $display("FAIL rm_ghost got=%0d want=0", obs_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sticky();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
